// File: rtl/uart_tx_mmio_if.sv
// Core data-RAM-port bundle for the memory-mapped UART transmitter.
// The core side drives the access strobe; the peripheral returns read data and the window hit.
interface uart_tx_mmio_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  ce_i;
    logic                  we_i;
    logic [ADDR_WIDTH-1:0] addr_i;
    logic [DATA_WIDTH-1:0] wdata_i;
    logic [DATA_WIDTH-1:0] rdata_o;
    logic                  hit_o;

    modport master (
        output ce_i, we_i, addr_i, wdata_i,
        input  rdata_o, hit_o
    );

    modport slave (
        input  ce_i, we_i, addr_i, wdata_i,
        output rdata_o, hit_o
    );
endinterface

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: 16-byte register window, TX FIFO, serialiser.
// Reads are combinational and writes never stall; pushes to a full FIFO are dropped and flagged.
module uart_tx_mmio #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = ADDR_WIDTH'(32'h1000_0000),
    parameter int unsigned           FIFO_DEPTH = 8,
    parameter logic [15:0]           DIV_RESET  = 16'd868
) (
    input  logic               clk_i,
    input  logic               rst_i,
    uart_tx_mmio_if.slave      bus,
    output logic               tx_o,
    output logic               idle_o
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    localparam logic [1:0] REG_TXDATA  = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_DIVISOR = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [7:0]       shift_q, shift_d;
    logic [15:0]      period_q, period_d;
    logic [15:0]      cyc_q, cyc_d;
    logic [2:0]       bit_q, bit_d;
    logic             tx_q, tx_d;
    logic             idle_q, idle_d;

    logic [7:0]       fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic [15:0]      div_q, div_d;

    logic             hit;
    logic             wr_acc;
    logic             txdata_wr;
    logic             push;
    logic             drop;
    logic             pop;
    logic             full;
    logic             empty;
    logic             busy;
    logic             bit_end;
    logic [31:0]      status_word;
    logic             unused_bits;

    // Window decode and register strobes
    assign hit       = bus.addr_i[ADDR_WIDTH-1:4] == BASE_ADDR[ADDR_WIDTH-1:4];
    assign wr_acc    = bus.ce_i && bus.we_i && hit;
    assign txdata_wr = wr_acc && (bus.addr_i[3:2] == REG_TXDATA);
    assign full      = count_q == CNT_W'(FIFO_DEPTH);
    assign empty     = count_q == '0;
    assign push      = txdata_wr && !full;
    assign drop      = txdata_wr && full;
    assign busy      = state_q != S_IDLE;
    assign bit_end   = cyc_q == (period_q - 16'd1);

    assign status_word = {20'd0, 4'(count_q), 4'd0, ovf_q, busy, empty, full};
    assign unused_bits = ^{bus.wdata_i[DATA_WIDTH-1:16], bus.addr_i[1:0]};

    assign bus.hit_o = hit;
    assign tx_o      = tx_q;
    assign idle_o    = idle_q;

    // Combinational read port
    always_comb begin
        bus.rdata_o = '0;
        if (bus.ce_i && !bus.we_i && hit) begin
            case (bus.addr_i[3:2])
                REG_STATUS:  bus.rdata_o = DATA_WIDTH'(status_word);
                REG_DIVISOR: bus.rdata_o = DATA_WIDTH'(div_q);
                default:     bus.rdata_o = '0;
            endcase
        end
    end

    // Next-state logic: serialiser FSM, FIFO bookkeeping, control registers
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        period_d = period_q;
        cyc_d    = cyc_q;
        bit_d    = bit_q;
        pop      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    shift_d  = fifo_mem[rd_ptr_q];
                    period_d = (div_q == 16'd0) ? 16'd1 : div_q;
                    cyc_d    = 16'd0;
                    bit_d    = 3'd0;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    cyc_d   = 16'd0;
                    state_d = S_DATA;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    cyc_d   = 16'd0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        bit_d   = 3'd0;
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    cyc_d = 16'd0;
                    // Chain straight into the next frame when data is waiting
                    if (!empty) begin
                        pop      = 1'b1;
                        shift_d  = fifo_mem[rd_ptr_q];
                        period_d = (div_q == 16'd0) ? 16'd1 : div_q;
                        state_d  = S_START;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase

        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        ovf_d = ovf_q;
        if (wr_acc && (bus.addr_i[3:2] == REG_STATUS) && bus.wdata_i[3]) begin
            ovf_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end

        div_d = div_q;
        if (wr_acc && (bus.addr_i[3:2] == REG_DIVISOR)) begin
            div_d = bus.wdata_i[15:0];
        end

        idle_d = (state_d == S_IDLE) && (count_d == '0);
    end

    // State registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            shift_q  <= 8'd0;
            period_q <= 16'd0;
            cyc_q    <= 16'd0;
            bit_q    <= 3'd0;
            tx_q     <= 1'b1;
            idle_q   <= 1'b1;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            div_q    <= DIV_RESET;
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            period_q <= period_d;
            cyc_q    <= cyc_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
            idle_q   <= idle_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            div_q    <= div_d;
        end
    end

    // FIFO storage; contents are don't-care until pushed
    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= bus.wdata_i[7:0];
        end
    end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Directed self-checking bench for uart_tx_mmio: register decode, FIFO/overflow,
// exact frame waveforms, back-to-back frames and mid-frame reset.
module tb_uart_tx_mmio;

    localparam logic [31:0] BASE = 32'h1000_0000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic tx;
    logic idle;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    uart_tx_mmio_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    uart_tx_mmio #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (8),
        .DIV_RESET  (16'd868)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .bus    (bus.slave),
        .tx_o   (tx),
        .idle_o (idle)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus.ce_i    = 1'b1;
        bus.we_i    = 1'b1;
        bus.addr_i  = addr;
        bus.wdata_i = data;
        @(posedge clk);
        #1;
        bus.ce_i = 1'b0;
        bus.we_i = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        bus.ce_i   = 1'b1;
        bus.we_i   = 1'b0;
        bus.addr_i = addr;
        #1;
        data = bus.rdata_o;
        bus.ce_i = 1'b0;
    endtask

    // Samples every cycle of one frame and the busy flag alongside it
    task automatic expect_frame(input logic [7:0] data, input int p);
        int bad = 0;
        int busy_bad = 0;
        for (int i = 0; i < 10 * p; i++) begin
            int idx;
            logic exp_bit;
            @(negedge clk);
            bus.ce_i   = 1'b1;
            bus.we_i   = 1'b0;
            bus.addr_i = BASE + 32'h4;
            #1;
            idx = i / p;
            if (idx == 0)      exp_bit = 1'b0;
            else if (idx == 9) exp_bit = 1'b1;
            else               exp_bit = data[idx-1];
            if (tx !== exp_bit) bad++;
            if (bus.rdata_o[2] !== 1'b1) busy_bad++;
            bus.ce_i = 1'b0;
        end
        check("frame_bits", 32'(bad), 32'd0);
        check("frame_busy", 32'(busy_bad), 32'd0);
    endtask

    // Line monitor for back-to-back traffic
    logic       mon_en = 1'b0;
    int         mon_p = 4;
    logic       m_act = 1'b0;
    int         m_cnt = 0;
    logic       m_bitv = 1'b1;
    logic [7:0] m_byte = 8'd0;
    int         m_glitch = 0;
    int         m_frame_err = 0;
    logic [7:0] m_bytes[$];
    int         m_starts[$];

    always @(negedge clk) begin
        if (mon_en) begin
            if (!m_act) begin
                if (tx == 1'b0) begin
                    m_act = 1'b1;
                    m_cnt = 0;
                    m_byte = 8'd0;
                    m_starts.push_back(cyc);
                end
            end else begin
                m_cnt++;
            end
            if (m_act) begin
                int idx;
                idx = m_cnt / mon_p;
                if (m_cnt % mon_p == 0) begin
                    m_bitv = tx;
                    if (idx == 0 && tx !== 1'b0) m_frame_err++;
                    if (idx >= 1 && idx <= 8) m_byte[idx-1] = tx;
                    if (idx == 9 && tx !== 1'b1) m_frame_err++;
                end else if (tx !== m_bitv) begin
                    m_glitch++;
                end
                if (m_cnt == 10 * mon_p - 1) begin
                    m_bytes.push_back(m_byte);
                    m_act = 1'b0;
                end
            end
        end
    end

    initial begin
        logic [31:0] rd;
        int lows;
        int gap_bad;
        int byte_bad;

        bus.ce_i    = 1'b0;
        bus.we_i    = 1'b0;
        bus.addr_i  = '0;
        bus.wdata_i = '0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        bus_read(BASE + 32'h4, rd);
        check("rst_status", rd, 32'h0000_0002);
        bus_read(BASE + 32'h8, rd);
        check("rst_divisor", rd, 32'h0000_0364);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_idle", 32'(idle), 32'd1);

        // Single frame 0x55 at 4 cycles per bit
        bus_write(BASE + 32'h8, 32'd4);
        bus_write(BASE + 32'h0, 32'h55);
        @(negedge clk);
        check("pre_start_tx", 32'(tx), 32'd1);
        expect_frame(8'h55, 4);
        @(negedge clk);
        check("post_frame_idle", 32'(idle), 32'd1);
        check("post_frame_tx", 32'(tx), 32'd1);

        // Fill past capacity: 10 writes, 9 accepted, 1 dropped
        mon_p  = 4;
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            bus_write(BASE + 32'h0, 32'(i));
        end
        bus_read(BASE + 32'h4, rd);
        check("full_status", rd, 32'h0000_080D);
        for (int i = 0; i < 2000 && !idle; i++) @(negedge clk);
        check("drain_idle", 32'(idle), 32'd1);
        mon_en = 1'b0;
        check("frame_count", 32'(m_bytes.size()), 32'd9);
        byte_bad = 0;
        foreach (m_bytes[i]) if (m_bytes[i] !== 8'(i)) byte_bad++;
        check("frame_bytes", 32'(byte_bad), 32'd0);
        gap_bad = 0;
        for (int i = 1; i < m_starts.size(); i++) begin
            if (m_starts[i] - m_starts[i-1] != 40) gap_bad++;
        end
        check("frame_spacing", 32'(gap_bad), 32'd0);
        check("frame_glitch", 32'(m_glitch), 32'd0);
        check("frame_err", 32'(m_frame_err), 32'd0);

        // Overflow is sticky; only bit 3 of a STATUS write clears it
        bus_read(BASE + 32'h4, rd);
        check("ovf_sticky", rd, 32'h0000_000A);
        bus_write(BASE + 32'h4, 32'h7);
        bus_read(BASE + 32'h4, rd);
        check("status_wr7_keep", rd, 32'h0000_000A);
        bus_write(BASE + 32'h4, 32'h8);
        bus_read(BASE + 32'h4, rd);
        check("ovf_clear", rd, 32'h0000_0002);
        bus_write(BASE + 32'h4, 32'h7);
        bus_read(BASE + 32'h4, rd);
        check("status_wr7_clean", rd, 32'h0000_0002);

        // Mid-frame reset with three bytes queued
        for (int i = 0; i < 4; i++) bus_write(BASE + 32'h0, 32'h0);
        repeat (14) @(negedge clk);
        check("mid_frame_tx", 32'(tx), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_tx", 32'(tx), 32'd1);
        check("rst_mid_idle", 32'(idle), 32'd1);
        bus_read(BASE + 32'h4, rd);
        check("rst_mid_status", rd, 32'h0000_0002);
        bus_read(BASE + 32'h8, rd);
        check("rst_mid_divisor", rd, 32'h0000_0364);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("rst_no_frames", 32'(lows), 32'd0);

        // Decode: outside window, reserved register, no strobe
        @(negedge clk);
        bus.addr_i = BASE + 32'h10;
        #1;
        check("miss_hit", 32'(bus.hit_o), 32'd0);
        bus.addr_i = BASE + 32'h8;
        #1;
        check("in_window_hit", 32'(bus.hit_o), 32'd1);
        check("no_ce_rdata", bus.rdata_o, 32'd0);
        bus_write(BASE + 32'h10, 32'h5A);
        bus_read(BASE + 32'h4, rd);
        check("miss_no_push", rd, 32'h0000_0002);
        bus_write(BASE + 32'hC, 32'hFFFF_FFFF);
        bus_read(BASE + 32'hC, rd);
        check("reserved_read", rd, 32'd0);
        bus_read(BASE + 32'h0, rd);
        check("txdata_read", rd, 32'd0);

        // Divisor 0 behaves as one cycle per bit
        bus_write(BASE + 32'h8, 32'd0);
        bus_read(BASE + 32'h8, rd);
        check("div0_read", rd, 32'd0);
        bus_write(BASE + 32'h0, 32'hA5);
        @(negedge clk);
        check("div0_pre_tx", 32'(tx), 32'd1);
        expect_frame(8'hA5, 1);
        @(negedge clk);
        check("div0_idle", 32'(idle), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
